// File: rtl/sd_data_rx_pkg.sv
// -----------------------------------------------------------------------------
// sd_data_rx_pkg
//   Shared definitions for the SD 4-bit data path. The receive block uses them
//   now; the transmit block will reuse them.
//   - CRC16-CCITT polynomial (x^16 + x^12 + x^5 + 1) and a one-bit step helper
//   - SD block geometry (512 bytes = 1024 nibbles on a 4-bit bus)
//   - Data-line FSM state encoding
// -----------------------------------------------------------------------------
package sd_data_rx_pkg;

  localparam logic [15:0] CRC16_POLY     = 16'h1021;
  localparam int          SD_BLOCK_BYTES = 512;
  localparam int          SD_NIBBLES     = SD_BLOCK_BYTES * 2;
  localparam int          SD_CRC_BITS    = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_DATA       = 3'd2,
    ST_CRC        = 3'd3,
    ST_END        = 3'd4
  } sd_state_e;

  // One serial CRC16 step, MSB-first, no reflection.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_crc16.sv
// -----------------------------------------------------------------------------
// sd_crc16
//   1-bit serial CRC16-CCITT accumulator, init 0x0000. One instance per SD data
//   line; shared by the receive and transmit paths.
// Ports
//   iclk  in  1   system clock
//   irst  in  1   synchronous reset, active-high (clears the CRC)
//   iclr  in  1   synchronous clear to 0x0000 (has priority over ien)
//   ien   in  1   shift ibit into the CRC this cycle
//   ibit  in  1   serial data bit
//   ocrc  out 16  current CRC register
// -----------------------------------------------------------------------------
module sd_crc16
  import sd_data_rx_pkg::*;
(
  input  logic        iclk,
  input  logic        irst,
  input  logic        iclr,
  input  logic        ien,
  input  logic        ibit,
  output logic [15:0] ocrc
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (iclr) begin
      crc_d = 16'h0000;
    end else if (ien) begin
      crc_d = crc16_step(crc_q, ibit);
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      crc_q <= 16'h0000;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign ocrc = crc_q;

endmodule

// File: rtl/sd_data_rx.sv
// -----------------------------------------------------------------------------
// sd_data_rx
//   Host-side SD 4-bit data receiver. Captures one data block from D[3:0],
//   writes each nibble to the block RAM, checks the four per-line CRC16s and
//   the end bit, and reports status.
//
//   Handshake: there is no valid/ready back-pressure. istrobe is a qualifier
//   meaning "D lines are valid now"; every strobe outside IDLE is consumed in
//   the cycle it is seen. owrite_en is a 1-cycle write strobe the RAM must
//   accept unconditionally; odone and otimeout are 1-cycle event pulses.
//
// Ports
//   iclk       in  1       system clock, single domain
//   irst       in  1       synchronous reset, active-high; aborts any block
//   istrobe    in  1       sample idata_sd this cycle (SD clock rising edge)
//   istart     in  1       arm for one block (ignored while busy)
//   idata_sd   in  4       sampled D[3:0], D3 = nibble MSB
//   owaddr     out ADDR_W  RAM write address (nibble index)
//   odin       out 4       RAM write data
//   owrite_en  out 1       RAM write enable, one cycle per nibble
//   obusy      out 1       armed / receiving
//   odone      out 1       block finished, ocrc_ok valid
//   ocrc_ok    out 1       CRCs matched and end bit was 4'hF (held)
//   otimeout   out 1       no start bit within TIMEOUT strobes
//   odbg_state out 3       current FSM state (sd_state_e encoding)
// -----------------------------------------------------------------------------
module sd_data_rx
  import sd_data_rx_pkg::*;
#(
  parameter int NIBBLES = SD_NIBBLES,
  parameter int ADDR_W  = $clog2(NIBBLES),
  parameter int TIMEOUT = 65535
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              istrobe,
  input  logic              istart,
  input  logic [3:0]        idata_sd,
  output logic [ADDR_W-1:0] owaddr,
  output logic [3:0]        odin,
  output logic              owrite_en,
  output logic              obusy,
  output logic              odone,
  output logic              ocrc_ok,
  output logic              otimeout,
  output logic [2:0]        odbg_state
);

  localparam int                TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] NIB_LAST = ADDR_W'(NIBBLES - 1);
  localparam logic [ADDR_W-1:0] CRC_LAST = ADDR_W'(SD_CRC_BITS - 1);

  sd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;       // nibble index in DATA, bit index in CRC
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              err_q, err_d;       // sticky CRC mismatch
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [3:0]        din_q, din_d;
  logic              wen_q, wen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              crc_ok_q, crc_ok_d;
  logic              tout_q, tout_d;

  logic              start_acc;
  logic              crc_clr;
  logic              crc_en;
  logic [15:0]       crc_val [4];
  logic [3:0]        crc_idx;
  logic [3:0]        crc_exp;

  // istart is only honoured in IDLE, which also makes a same-cycle istrobe
  // a no-op: IDLE never samples the data lines.
  assign start_acc = istart && (state_q == ST_IDLE);
  assign crc_clr   = start_acc;
  assign crc_en    = istrobe && (state_q == ST_DATA);

  for (genvar k = 0; k < 4; k++) begin : g_crc
    sd_crc16 u_crc (
      .iclk (iclk),
      .irst (irst),
      .iclr (crc_clr),
      .ien  (crc_en),
      .ibit (idata_sd[k]),
      .ocrc (crc_val[k])
    );
  end

  // During the CRC phase the registers are frozen; the card sends them MSB
  // first, so bit (15 - cnt) of each line's register is the expected bit.
  assign crc_idx = 4'd15 - cnt_q[3:0];

  always_comb begin
    crc_exp = 4'h0;
    for (int k = 0; k < 4; k++) begin
      crc_exp[k] = crc_val[k][crc_idx];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    err_d    = err_q;
    waddr_d  = waddr_q;
    din_d    = din_q;
    wen_d    = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    crc_ok_d = crc_ok_q;
    tout_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (istart) begin
          cnt_d    = '0;
          tmr_d    = '0;
          err_d    = 1'b0;
          crc_ok_d = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_WAIT_START;
        end
      end

      ST_WAIT_START: begin
        if (istrobe) begin
          // Only all four lines low is a start bit; partial lows keep waiting.
          if (idata_sd == 4'h0) begin
            cnt_d   = '0;
            state_d = ST_DATA;
          end else if (tmr_q == TMR_LAST) begin
            tout_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (istrobe) begin
          wen_d   = 1'b1;
          waddr_d = cnt_q;
          din_d   = idata_sd;
          if (cnt_q == NIB_LAST) begin
            cnt_d   = '0;
            state_d = ST_CRC;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_CRC: begin
        if (istrobe) begin
          if (idata_sd != crc_exp) begin
            err_d = 1'b1;
          end
          if (cnt_q == CRC_LAST) begin
            cnt_d   = '0;
            state_d = ST_END;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_END: begin
        if (istrobe) begin
          done_d   = 1'b1;
          busy_d   = 1'b0;
          crc_ok_d = !err_q && (idata_sd == 4'hF);
          state_d  = ST_IDLE;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      tmr_q    <= '0;
      err_q    <= 1'b0;
      waddr_q  <= '0;
      din_q    <= 4'h0;
      wen_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      crc_ok_q <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      err_q    <= err_d;
      waddr_q  <= waddr_d;
      din_q    <= din_d;
      wen_q    <= wen_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      crc_ok_q <= crc_ok_d;
      tout_q   <= tout_d;
    end
  end

  assign owaddr     = waddr_q;
  assign odin       = din_q;
  assign owrite_en  = wen_q;
  assign obusy      = busy_q;
  assign odone      = done_q;
  assign ocrc_ok    = crc_ok_q;
  assign otimeout   = tout_q;
  assign odbg_state = state_q;

endmodule

// File: tb/tb_sd_data_rx.sv
// -----------------------------------------------------------------------------
// tb_sd_data_rx
//   Bench for sd_data_rx with NIBBLES=1024, TIMEOUT=16. Blocks are generated
//   in the bench, their line CRCs come from a polynomial-division model, and a
//   compare process checks every write / done / timeout event against queues
//   of expected (cycle, value) entries filled by the driver tasks.
// -----------------------------------------------------------------------------
module tb_sd_data_rx;

  localparam int NIB  = 1024;
  localparam int AW   = 10;
  localparam int TOUT = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          istrobe = 1'b0;
  logic          istart = 1'b0;
  logic [3:0]    idata = 4'h0;
  logic [AW-1:0] owaddr;
  logic [3:0]    odin;
  logic          owrite_en, obusy, odone, ocrc_ok, otimeout;
  logic [2:0]    odbg_state;

  sd_data_rx #(.NIBBLES(NIB), .ADDR_W(AW), .TIMEOUT(TOUT)) dut (
    .iclk       (clk),
    .irst       (rst),
    .istrobe    (istrobe),
    .istart     (istart),
    .idata_sd   (idata),
    .owaddr     (owaddr),
    .odin       (odin),
    .owrite_en  (owrite_en),
    .obusy      (obusy),
    .odone      (odone),
    .ocrc_ok    (ocrc_ok),
    .otimeout   (otimeout),
    .odbg_state (odbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  int tests = 0;
  int fails = 0;

  // ---------------- scoreboard queues ----------------
  logic [45:0] exp_q[$];   // {cycle, addr, data} expected RAM writes
  logic [32:0] done_q[$];  // {cycle, crc_ok}
  logic [31:0] tout_q[$];  // cycle of expected otimeout

  // ---------------- behavioural model ----------------
  logic [3:0]  blk [0:NIB-1];
  logic [15:0] line_crc [0:3];
  bit          mbits [0:8191];

  // Remainder of M(x) * x^16 divided by the generator, i.e. CRC with init 0.
  function automatic logic [15:0] model_crc(input int len);
    logic [16:0] rem;
    rem = '0;
    for (int i = 0; i < len + 16; i++) begin
      rem = {rem[15:0], (i < len) ? mbits[i] : 1'b0};
      if (rem[16]) rem = rem ^ 17'h11021;
    end
    return rem[15:0];
  endfunction

  task automatic compute_line_crcs();
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < NIB; n++) mbits[n] = blk[n][k];
      line_crc[k] = model_crc(NIB);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0][45:14] < cyc) begin
      tests++; fails++;
      $display("FAIL write_missing: addr %0d not written in cycle %0d", exp_q[0][13:4], exp_q[0][45:14]);
      void'(exp_q.pop_front());
    end
    if (owrite_en) begin
      tests++;
      if (exp_q.size() == 0 || exp_q[0][45:14] != cyc) begin
        fails++;
        $display("FAIL write_unexpected: addr %0d data 0x%0h at cycle %0d, none expected", owaddr, odin, cyc);
      end else begin
        if (owaddr !== exp_q[0][13:4] || odin !== exp_q[0][3:0]) begin
          fails++;
          $display("FAIL write_data: got addr %0d data 0x%0h, expected addr %0d data 0x%0h",
                   owaddr, odin, exp_q[0][13:4], exp_q[0][3:0]);
        end
        void'(exp_q.pop_front());
      end
    end

    while (done_q.size() > 0 && done_q[0][32:1] < cyc) begin
      tests++; fails++;
      $display("FAIL done_missing: odone not seen in cycle %0d", done_q[0][32:1]);
      void'(done_q.pop_front());
    end
    if (odone) begin
      tests++;
      if (done_q.size() == 0 || done_q[0][32:1] != cyc) begin
        fails++;
        $display("FAIL done_unexpected: odone at cycle %0d, none expected", cyc);
      end else begin
        if (ocrc_ok !== done_q[0][0]) begin
          fails++;
          $display("FAIL done_crc_ok: got %0b, expected %0b", ocrc_ok, done_q[0][0]);
        end
        void'(done_q.pop_front());
      end
    end

    while (tout_q.size() > 0 && tout_q[0] < cyc) begin
      tests++; fails++;
      $display("FAIL timeout_missing: otimeout not seen in cycle %0d", tout_q[0]);
      void'(tout_q.pop_front());
    end
    if (otimeout) begin
      tests++;
      if (tout_q.size() == 0 || tout_q[0] != cyc) begin
        fails++;
        $display("FAIL timeout_unexpected: otimeout at cycle %0d, none expected", cyc);
      end else begin
        void'(tout_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One strobe; sc returns the cycle in which it is sampled-from, so the
  // registered response is expected at sc + 1.
  task automatic strobe(input logic [3:0] d, input bit st, output logic [31:0] sc);
    repeat ($urandom_range(0, 1)) @(posedge clk);
    @(posedge clk); #1;
    istrobe = 1'b1; istart = st; idata = d; sc = cyc;
    @(posedge clk); #1;
    istrobe = 1'b0; istart = 1'b0; idata = 4'($urandom);
  endtask

  task automatic do_start(input bit with_strobe);
    @(posedge clk); #1;
    istart = 1'b1;
    if (with_strobe) begin istrobe = 1'b1; idata = 4'h0; end
    @(posedge clk); #1;
    istart = 1'b0; istrobe = 1'b0;
    chk("busy_after_start", {31'd0, obusy}, 32'd1);
    chk("crc_ok_cleared", {31'd0, ocrc_ok}, 32'd0);
  endtask

  task automatic send_block(input int n_data, input logic [3:0] end_nib, input bit flip,
                            input bit arm_strobe, input bit busy_starts);
    logic [31:0] sc;
    logic [15:0] c [4];
    logic [3:0]  nib;
    bit          ok;
    do_start(arm_strobe);
    repeat ($urandom_range(0, 4)) strobe(4'($urandom_range(1, 15)), 1'b0, sc);
    strobe(4'h0, 1'b0, sc);
    for (int n = 0; n < n_data; n++) begin
      strobe(blk[n], busy_starts && ($urandom_range(0, 63) == 0), sc);
      exp_q.push_back({sc + 32'd1, 10'(n), blk[n]});
    end
    if (n_data < NIB) return;
    compute_line_crcs();
    for (int k = 0; k < 4; k++) c[k] = line_crc[k];
    if (flip) c[2][7] = ~c[2][7];
    for (int i = 0; i < 16; i++) begin
      nib = {c[3][15-i], c[2][15-i], c[1][15-i], c[0][15-i]};
      strobe(nib, 1'b0, sc);
    end
    ok = !flip && (end_nib == 4'hF);
    strobe(end_nib, 1'b0, sc);
    done_q.push_back({sc + 32'd1, ok});
    repeat (3) @(posedge clk); #1;
    chk("busy_after_done", {31'd0, obusy}, 32'd0);
    chk("crc_ok_held", {31'd0, ocrc_ok}, {31'd0, ok});
  endtask

  task automatic run_timeout(input int mode, input bit arm_strobe);
    logic [31:0] sc;
    logic [3:0]  d;
    do_start(arm_strobe);
    for (int i = 0; i < TOUT; i++) begin
      d = (mode == 0) ? 4'hF : (mode == 1) ? 4'h7 : 4'($urandom_range(1, 15));
      strobe(d, 1'b0, sc);
      if (i == TOUT - 2) chk("busy_before_timeout", {31'd0, obusy}, 32'd1);
    end
    tout_q.push_back(sc + 32'd1);
    chk("busy_after_timeout", {31'd0, obusy}, 32'd0);
    // Receiver is idle again: start-like data must not produce writes.
    repeat (3) strobe(4'h0, 1'b0, sc);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_waddr"}, 32'(owaddr), 32'd0);
    chk({tag, "_din"}, 32'(odin), 32'd0);
    chk({tag, "_wen"}, {31'd0, owrite_en}, 32'd0);
    chk({tag, "_busy"}, {31'd0, obusy}, 32'd0);
    chk({tag, "_done"}, {31'd0, odone}, 32'd0);
    chk({tag, "_crc_ok"}, {31'd0, ocrc_ok}, 32'd0);
    chk({tag, "_timeout"}, {31'd0, otimeout}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] ascii [9];
  logic [31:0] sc_dummy;

  initial begin
    // Pin the CRC model with known values.
    mbits[0] = 1'b1;
    chk("model_single_one", 32'(model_crc(1)), 32'h1021);
    ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int b = 0; b < 9; b++)
      for (int j = 0; j < 8; j++) mbits[b*8 + j] = ascii[b][7-j];
    chk("model_123456789", 32'(model_crc(72)), 32'h31C3);
    for (int n = 0; n < NIB; n++) blk[n] = 4'h0;
    compute_line_crcs();
    chk("model_zero_line", 32'(line_crc[1]), 32'h0);

    repeat (3) @(posedge clk); #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // All-zero block.
    send_block(NIB, 4'hF, 1'b0, 1'b0, 1'b0);
    // Ramp block, armed with a simultaneous strobe that must be ignored.
    for (int n = 0; n < NIB; n++) blk[n] = 4'(n);
    send_block(NIB, 4'hF, 1'b0, 1'b1, 1'b0);
    // Ramp block with D2 CRC bit 7 corrupted.
    send_block(NIB, 4'hF, 1'b1, 1'b0, 1'b0);
    // Random data, correct CRC, bad end bit, stray istart pulses while busy.
    for (int n = 0; n < NIB; n++) blk[n] = 4'($urandom);
    send_block(NIB, 4'hE, 1'b0, 1'b0, 1'b1);

    // Timeouts.
    run_timeout(0, 1'b0);
    run_timeout(1, 1'b1);
    run_timeout(2, 1'b0);

    // Random good block.
    for (int n = 0; n < NIB; n++) blk[n] = 4'($urandom);
    send_block(NIB, 4'hF, 1'b0, 1'b0, 1'b1);

    // Reset after 300 writes, then a full block.
    for (int n = 0; n < NIB; n++) blk[n] = 4'($urandom);
    send_block(300, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("busy_mid_block", {31'd0, obusy}, 32'd1);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("midreset");
    rst = 1'b0;
    repeat (5) strobe(4'($urandom), 1'b0, sc_dummy);
    for (int n = 0; n < NIB; n++) blk[n] = 4'($urandom);
    send_block(NIB, 4'hF, 1'b0, 1'b1, 1'b0);

    repeat (10) @(posedge clk); #1;
    chk("writes_drained", 32'(exp_q.size()), 32'd0);
    chk("dones_drained", 32'(done_q.size()), 32'd0);
    chk("timeouts_drained", 32'(tout_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard bound on simulation length.
  initial begin
    #2000000;
    $display("FAIL sim_time_limit: bench did not complete within time bound");
    $fatal(1, "time limit");
  end

endmodule
